// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode codes and bounce/breathe direction shared by the LED pattern generator
package led_pattern_pkg;
    localparam int MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_BIN     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_CHASE   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BOUNCE  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_BREATHE = 2'd3;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// tick_prescaler: divides the clock into a one-cycle step tick every DIV cycles
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clear,
    input  logic i_En,
    output logic o_Tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt;
    assign o_Tick = i_En && !i_Clear && cnt == LAST;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) cnt <= '0;
        else if (i_Clear) cnt <= '0;
        else if (i_En) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: run-time selectable LED patterns (binary, chase, bounce, PWM breathe)
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int CLK_HZ    = 25_000_000,
    parameter int STEP_HZ   = 4,
    parameter int PWM_BITS  = 8,
    parameter int DUTY_STEP = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [MODE_W-1:0]   i_Mode,
    input  logic                i_Pause,
    output logic                o_Tick,
    output logic [NUM_LEDS-1:0] o_LED
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam logic [PWM_BITS-1:0] DMAX  = '1;
    localparam logic [PWM_BITS-1:0] DSTEP = PWM_BITS'(DUTY_STEP);
    if (DIV < 2) begin : g_div_chk
        $error("led_pattern_gen: CLK_HZ/STEP_HZ must be >= 2");
    end
    logic [MODE_W-1:0]   mode_q;
    logic [NUM_LEDS-1:0] pat, pat_nxt, bnc;
    logic [PWM_BITS-1:0] duty, duty_nxt, pwm_cnt;
    logic [PWM_BITS:0]   sum;
    dir_e                dir, dir_nxt;
    logic                mode_chg;
    assign mode_chg = i_Mode != mode_q;
    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clear (mode_chg),
        .i_En    (!i_Pause),
        .o_Tick  (o_Tick)
    );
    // sum carries an extra bit so the breathe ramp can detect overshoot past DMAX
    always_comb begin
        sum = {1'b0, duty} + {1'b0, DSTEP};
        bnc = (NUM_LEDS == 1) ? pat : (dir == DIR_UP) ? pat << 1 : pat >> 1;
        pat_nxt = (mode_q == MODE_BIN)    ? pat + 1'b1 :
                  (mode_q == MODE_CHASE)  ? (pat << 1) | (pat >> (NUM_LEDS - 1)) :
                  (mode_q == MODE_BOUNCE) ? bnc : pat;
        duty_nxt = (mode_q != MODE_BREATHE) ? duty :
                   (dir == DIR_UP) ? (sum[PWM_BITS] ? DMAX : sum[PWM_BITS-1:0]) :
                   (duty < DSTEP) ? '0 : duty - DSTEP;
        dir_nxt = (mode_q == MODE_BOUNCE)  ? ((dir == DIR_UP) ? (bnc[NUM_LEDS-1] ? DIR_DOWN : DIR_UP)
                                                              : (bnc[0] ? DIR_UP : DIR_DOWN)) :
                  (mode_q == MODE_BREATHE) ? ((dir == DIR_UP) ? (sum[PWM_BITS] ? DIR_DOWN : DIR_UP)
                                                              : ((duty < DSTEP) ? DIR_UP : DIR_DOWN)) :
                  dir;
    end
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mode_q  <= MODE_BIN;
            pat     <= '0;
            dir     <= DIR_UP;
            duty    <= '0;
            pwm_cnt <= '0;
            o_LED   <= '0;
        end else begin
            if (!i_Pause) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                o_LED   <= (mode_q == MODE_BREATHE) ? {NUM_LEDS{pwm_cnt < duty}} : pat;
            end
            if (mode_chg) begin
                mode_q <= i_Mode;
                pat    <= (i_Mode == MODE_BIN) ? '0 : NUM_LEDS'(1);
                dir    <= DIR_UP;
                duty   <= '0;
            end else if (o_Tick) begin
                pat  <= pat_nxt;
                dir  <= dir_nxt;
                duty <= duty_nxt;
            end
        end
    end
endmodule
